nvdla_cdp_rdma_reg_group_ctrl: RTL and testbench
================================================

# nvdla_cdp_rdma_reg_group_ctrl

Parametrised single-register-space controller for the CDP RDMA register groups. It generalises the fixed two-group producer/consumer scheme to GROUPS groups and owns per-group op_en flags. It also runs a sequencer that launches the datapath on the consumer group, advances the consumer on completion, and counts completed operations. It sits between the CSB register decode and the RDMA datapath.

## Interface

Parameters:
- GROUPS, 2: number of register groups; legal values 2, 4, 8.
- PTR_W, derived = log2(GROUPS): width of producer/consumer pointers.

Ports:
- nvdla_core_clk  in  1  core clock; all flops on its rising edge.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- reg_offset  in  12  register byte offset.
- reg_wr_data  in  32  write data.
- reg_wr_en  in  1  write strobe, single cycle per write.
- reg_rd_data  out  32  combinational read data for reg_offset.
- producer  out  PTR_W  software-programmed group pointer.
- consumer  out  PTR_W  group currently owned by the datapath.
- grp_op_en  out  GROUPS  per-group op_en flags.
- dp_start  out  1  one-cycle launch pulse to datapath.
- dp_group  out  PTR_W  group being executed; equals consumer.
- dp_done  in  1  one-cycle completion pulse from datapath.
- intr_done  out  1  one-cycle completion pulse to interrupt logic.

## Operation

Register map (offsets in the 12-bit space):
- 0x000 STATUS, read-only. Bits [4g+1:4g] hold the status of group g: 0 = idle, 1 = running, 2 = pending. All other bits are 0. Writes are ignored.
- 0x004 POINTER. Bits [PTR_W-1:0] hold producer and are read/write. Bits [16+PTR_W-1:16] hold consumer and are read-only. All other bits read 0.
- 0x008 OP_EN. A write of 1 to bit g sets grp_op_en[g] only if group g is idle. Writes of 0 have no effect. Reads return grp_op_en, zero-extended.
- 0x00C DONE_CNT. Bits [15:0] count completed operations and saturate at 0xFFFF. Any write clears the count.
- Any other offset reads 0, and writes to it are ignored.

Group status:
- Idle when grp_op_en[g] = 0.
- Running when grp_op_en[g] = 1, g = consumer and the FSM is BUSY.
- Pending otherwise.

Sequencer FSM, two states:
- IDLE -> BUSY when grp_op_en[consumer] = 1. dp_start is asserted for exactly the first BUSY cycle.
- BUSY -> IDLE on dp_done. On the same edge: clear grp_op_en[consumer], set consumer to (consumer+1) mod GROUPS, pulse intr_done for one cycle, and increment DONE_CNT.
- dp_done in IDLE is ignored: no count, no pointer move, no interrupt.

Producer behaviour:
- producer is informational only; it does not gate sequencing.

Boundary rules:
- An OP_EN write to the running group is ignored.
- An OP_EN write and a dp_done in the same cycle: dp_done is applied, and the write's set-bits for non-running groups are applied. The running group's bit ends at 0.
- A DONE_CNT write and a dp_done in the same cycle: the clear wins, so the count ends at 0.
- Consumer wraps from GROUPS-1 to 0.
- Assertion of reset mid-operation immediately clears all state. The datapath must be reset by the same rstn.

Reset values: producer 0, consumer 0, grp_op_en 0, FSM IDLE, dp_start 0, intr_done 0, DONE_CNT 0. reg_rd_data follows the mux, so STATUS and POINTER read 0 after reset.

## Timing

- Register writes take effect on the edge where reg_wr_en is high. The new value is readable in the next cycle.
- Read path is purely combinational from reg_offset and the flops, with no latency.
- Op_en to launch: an OP_EN write on edge t gives dp_start high in the cycle after edge t+1. That is 2 cycles from the write cycle for an idle consumer group.
- Done to next launch: dp_done sampled on edge t advances consumer at t. If the new consumer's op_en is already set, the next dp_start is high after edge t+1.
- dp_start and intr_done are registered, single-cycle pulses, and are never high in consecutive cycles for the same operation.

## Test plan

- Reset with GROUPS=2: all outputs 0. Reading 0x004 returns 0x00000000 and reading 0x000 returns 0x00000000.
- Write 0x008 = 0x1 and hold dp_done low: after 2 cycles dp_start pulses with dp_group=0. STATUS then reads 0x00000001.
- With group 0 running, write 0x008 = 0x2, then pulse dp_done:
  - STATUS reads 0x00000021 before dp_done.
  - After dp_done: intr_done pulses, consumer=1, and POINTER reads 0x00010000.
  - dp_start for group 1 follows one cycle later.
  - DONE_CNT reads 1.
- GROUPS=4: launch and complete groups 0..3 in order. Consumer wraps 3 -> 0 and DONE_CNT reads 4.
- Boundary cases:
  - dp_done while IDLE: no change.
  - Write 0x008 = 0x1 while group 0 is running: ignored.
  - Write 0x00C in the same cycle as dp_done: DONE_CNT reads 0.
  - Write 0x000 = 0xFFFFFFFF: STATUS is unchanged.
- Force DONE_CNT to 0xFFFF via 65535 completions and then complete one more: the count stays at 0xFFFF. Assert rstn mid-BUSY: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/nvdla_cdp_rdma_reg_group_ctrl.sv
// CDP RDMA register-group controller: GROUPS register groups with per-group op_en flags,
// a producer/consumer pointer pair, and a two-state launch/complete sequencer.
module nvdla_cdp_rdma_reg_group_ctrl #(
    parameter int unsigned GROUPS = 2,
    parameter int unsigned PTR_W  = $clog2(GROUPS)
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic [11:0]       reg_offset,
    input  logic [31:0]       reg_wr_data,
    input  logic              reg_wr_en,
    output logic [31:0]       reg_rd_data,
    output logic [PTR_W-1:0]  producer,
    output logic [PTR_W-1:0]  consumer,
    output logic [GROUPS-1:0] grp_op_en,
    output logic              dp_start,
    output logic [PTR_W-1:0]  dp_group,
    input  logic              dp_done,
    output logic              intr_done
);

    localparam logic [11:0] OffStatus  = 12'h000;
    localparam logic [11:0] OffPointer = 12'h004;
    localparam logic [11:0] OffOpEn    = 12'h008;
    localparam logic [11:0] OffDoneCnt = 12'h00C;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  producer_q, producer_d;
    logic [PTR_W-1:0]  consumer_q, consumer_d;
    logic [GROUPS-1:0] op_en_q, op_en_d;
    logic [15:0]       done_cnt_q, done_cnt_d;
    logic              dp_start_q, dp_start_d;
    logic              intr_done_q, intr_done_d;

    logic wr_pointer;
    logic wr_op_en;
    logic wr_done_cnt;
    logic done_fire;
    logic unused_wr_data;

    assign wr_pointer  = reg_wr_en && (reg_offset == OffPointer);
    assign wr_op_en    = reg_wr_en && (reg_offset == OffOpEn);
    assign wr_done_cnt = reg_wr_en && (reg_offset == OffDoneCnt);
    assign done_fire   = (state_q == StBusy) && dp_done;

    // Only the low bits of write data carry meaning for any register.
    assign unused_wr_data = ^reg_wr_data;

    // Sequencer and op_en flags
    always_comb begin
        state_d     = state_q;
        consumer_d  = consumer_q;
        dp_start_d  = 1'b0;
        intr_done_d = 1'b0;
        op_en_d     = op_en_q;

        // Set-only write; bits already set (pending or running) are unaffected by an OR.
        if (wr_op_en) begin
            op_en_d = op_en_q | reg_wr_data[GROUPS-1:0];
        end

        unique case (state_q)
            StIdle: begin
                if (op_en_q[consumer_q]) begin
                    state_d    = StBusy;
                    dp_start_d = 1'b1;
                end
            end
            StBusy: begin
                if (dp_done) begin
                    state_d             = StIdle;
                    op_en_d[consumer_q] = 1'b0;
                    consumer_d          = consumer_q + PTR_W'(1);
                    intr_done_d         = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        producer_d = producer_q;
        if (wr_pointer) begin
            producer_d = reg_wr_data[PTR_W-1:0];
        end
    end

    // Software clear takes priority over a coincident completion.
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (wr_done_cnt) begin
            done_cnt_d = 16'h0000;
        end else if (done_fire && (done_cnt_q != 16'hFFFF)) begin
            done_cnt_d = done_cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= StIdle;
            producer_q  <= '0;
            consumer_q  <= '0;
            op_en_q     <= '0;
            done_cnt_q  <= 16'h0000;
            dp_start_q  <= 1'b0;
            intr_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            producer_q  <= producer_d;
            consumer_q  <= consumer_d;
            op_en_q     <= op_en_d;
            done_cnt_q  <= done_cnt_d;
            dp_start_q  <= dp_start_d;
            intr_done_q <= intr_done_d;
        end
    end

    // Combinational read mux
    always_comb begin
        reg_rd_data = 32'h0000_0000;
        case (reg_offset)
            OffStatus: begin
                for (int g = 0; g < int'(GROUPS); g++) begin
                    if (op_en_q[g]) begin
                        if ((consumer_q == PTR_W'(g)) && (state_q == StBusy)) begin
                            reg_rd_data[4*g +: 2] = 2'd1;
                        end else begin
                            reg_rd_data[4*g +: 2] = 2'd2;
                        end
                    end
                end
            end
            OffPointer: begin
                reg_rd_data[PTR_W-1:0]  = producer_q;
                reg_rd_data[16 +: PTR_W] = consumer_q;
            end
            OffOpEn: begin
                reg_rd_data[GROUPS-1:0] = op_en_q;
            end
            OffDoneCnt: begin
                reg_rd_data[15:0] = done_cnt_q;
            end
            default: reg_rd_data = 32'h0000_0000;
        endcase
    end

    assign producer  = producer_q;
    assign consumer  = consumer_q;
    assign dp_group  = consumer_q;
    assign grp_op_en = op_en_q;
    assign dp_start  = dp_start_q;
    assign intr_done = intr_done_q;

endmodule

// File: tb/tb_nvdla_cdp_rdma_reg_group_ctrl.sv
// Scoreboard bench for nvdla_cdp_rdma_reg_group_ctrl (GROUPS=4): directed cases, random
// traffic against a behavioural model, saturation and asynchronous reset.
module tb_nvdla_cdp_rdma_reg_group_ctrl;

    localparam int G = 4;
    localparam int W = 2;

    logic          clk;
    logic          rstn;
    logic [11:0]   reg_offset;
    logic [31:0]   reg_wr_data;
    logic          reg_wr_en;
    logic [31:0]   reg_rd_data;
    logic [W-1:0]  producer;
    logic [W-1:0]  consumer;
    logic [G-1:0]  grp_op_en;
    logic          dp_start;
    logic [W-1:0]  dp_group;
    logic          dp_done;
    logic          intr_done;

    nvdla_cdp_rdma_reg_group_ctrl #(.GROUPS(G)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .reg_offset      (reg_offset),
        .reg_wr_data     (reg_wr_data),
        .reg_wr_en       (reg_wr_en),
        .reg_rd_data     (reg_rd_data),
        .producer        (producer),
        .consumer        (consumer),
        .grp_op_en       (grp_op_en),
        .dp_start        (dp_start),
        .dp_group        (dp_group),
        .dp_done         (dp_done),
        .intr_done       (intr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    // Expected pulse events: 0*16+grp for a launch, 1*16+grp for a completion.
    int sb_q[$];

    // Behavioural model state
    logic [G-1:0] m_op;
    int           m_cons;
    int           m_prod;
    bit           m_busy;
    int           m_cnt;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] off);
        logic [31:0] r;
        r = 32'h0;
        case (off)
            12'h000: for (int g = 0; g < G; g++)
                         if (m_op[g]) r[4*g +: 2] = (m_busy && g == m_cons) ? 2'd1 : 2'd2;
            12'h004: r = m_prod + m_cons * 65536;
            12'h008: r = 32'(m_op);
            12'h00C: r = m_cnt;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_op = '0; m_cons = 0; m_prod = 0; m_busy = 0; m_cnt = 0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic we, input logic [11:0] off, input logic [31:0] d,
                              input logic dn);
        bit           fin;
        bit           launch;
        logic [G-1:0] op_n;
        fin    = m_busy && dn;
        launch = !m_busy && m_op[m_cons];
        op_n   = m_op;
        if (we && off == 12'h008)
            for (int g = 0; g < G; g++) if (d[g] && !m_op[g]) op_n[g] = 1'b1;
        if (fin) begin
            op_n[m_cons] = 1'b0;
            sb_q.push_back(16 + m_cons);
            m_cons = (m_cons + 1) % G;
            m_busy = 0;
        end
        if (launch) begin
            m_busy = 1;
            sb_q.push_back(m_cons);
        end
        if (we && off == 12'h00C) m_cnt = 0;
        else if (fin && m_cnt < 65535) m_cnt++;
        if (we && off == 12'h004) m_prod = d % G;
        m_op = op_n;
    endtask

    // One clock: drive at negedge, update model at posedge, compare shortly after.
    task automatic cyc(input logic we, input logic [11:0] off, input logic [31:0] d,
                       input logic dn);
        logic [11:0] offs [6];
        logic [11:0] ro;
        offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h7FC};
        @(negedge clk);
        reg_wr_en = we; reg_offset = off; reg_wr_data = d; dp_done = dn;
        @(posedge clk);
        model_step(we, off, d, dn);
        #2;
        reg_wr_en = 1'b0; dp_done = 1'b0;
        ro = offs[$urandom_range(0, 5)];
        reg_offset = ro;
        #1;
        check("consumer", 32'(consumer), m_cons);
        check("producer", 32'(producer), m_prod);
        check("grp_op_en", 32'(grp_op_en), 32'(m_op));
        check($sformatf("read_0x%03h", ro), reg_rd_data, m_read(ro));
    endtask

    task automatic rd(input logic [11:0] off, input logic [31:0] exp, input string name);
        reg_offset = off;
        #1;
        check(name, reg_rd_data, exp);
    endtask

    // Monitor: pops an expected event whenever the DUT pulses.
    always @(negedge clk) begin
        int code;
        if (rstn) begin
            if (dp_start) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL start_unexpected: got dp_start group %0d, required none", dp_group);
                end else begin
                    code = sb_q.pop_front();
                    check("start_event", 32'(dp_group), code);
                end
            end
            if (intr_done) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL intr_unexpected: got intr_done, required none");
                end else begin
                    code = sb_q.pop_front();
                    check("intr_event", 16 + (int'(consumer) + G - 1) % G, code);
                end
            end
        end
    end

    initial begin
        logic [11:0] roffs [7];
        checks = 0; failures = 0;
        roffs = '{12'h008, 12'h008, 12'h008, 12'h004, 12'h000, 12'h00C, 12'h010};
        rstn = 1'b0; reg_offset = 12'h0; reg_wr_data = 32'h0; reg_wr_en = 1'b0; dp_done = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("rst_dp_start", 32'(dp_start), 0);
        check("rst_intr_done", 32'(intr_done), 0);
        check("rst_grp_op_en", 32'(grp_op_en), 0);
        rd(12'h004, 32'h0, "rst_pointer");
        rd(12'h000, 32'h0, "rst_status");
        @(negedge clk);
        rstn = 1'b1;

        // Launch group 0 two cycles after the OP_EN write
        cyc(1, 12'h008, 32'h1, 0);
        check("launch_early", 32'(dp_start), 0);
        cyc(0, 12'h000, 32'h0, 0);
        check("launch_g0", 32'(dp_start), 1);
        check("launch_g0_group", 32'(dp_group), 0);
        rd(12'h000, 32'h1, "status_g0_run");

        // Queue group 1 behind running group 0, then complete
        cyc(1, 12'h008, 32'h2, 0);
        rd(12'h000, 32'h21, "status_run_pend");
        cyc(0, 12'h000, 32'h0, 1);
        check("intr_g0", 32'(intr_done), 1);
        rd(12'h004, 32'h0001_0000, "pointer_after_done");
        cyc(0, 12'h000, 32'h0, 0);
        check("launch_g1", 32'(dp_start), 1);
        check("launch_g1_group", 32'(dp_group), 1);
        rd(12'h00C, 32'h1, "done_cnt_1");

        // Finish groups 1..3; consumer wraps to 0
        cyc(0, 12'h000, 32'h0, 1);
        cyc(1, 12'h008, 32'hC, 0);
        cyc(0, 12'h000, 32'h0, 0);
        cyc(0, 12'h000, 32'h0, 1);
        cyc(0, 12'h000, 32'h0, 0);
        cyc(0, 12'h000, 32'h0, 1);
        check("wrap_consumer", 32'(consumer), 0);
        rd(12'h00C, 32'h4, "done_cnt_4");

        // dp_done while idle is ignored
        cyc(0, 12'h000, 32'h0, 1);
        check("idle_done_intr", 32'(intr_done), 0);
        rd(12'h00C, 32'h4, "idle_done_cnt");

        // OP_EN write to the running group, then OP_EN write coincident with dp_done
        cyc(1, 12'h008, 32'h1, 0);
        cyc(0, 12'h000, 32'h0, 0);
        cyc(1, 12'h008, 32'h1, 0);
        rd(12'h000, 32'h1, "run_write_ignored");
        cyc(1, 12'h008, 32'h3, 1);
        rd(12'h008, 32'h2, "op_en_with_done");

        // DONE_CNT clear coincident with dp_done
        cyc(0, 12'h000, 32'h0, 0);
        cyc(1, 12'h00C, 32'h0, 1);
        rd(12'h00C, 32'h0, "clear_wins");

        // STATUS is read-only; producer is writable
        cyc(1, 12'h000, 32'hFFFF_FFFF, 0);
        rd(12'h000, 32'h0, "status_ro");
        cyc(1, 12'h004, 32'hFFFF_FFFF, 0);
        rd(12'h004, 32'h0002_0003, "producer_wr");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 2) == 0), roffs[$urandom_range(0, 6)], $urandom(),
                ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset while busy
        for (int i = 0; i < 20 && !m_busy; i++) cyc(1, 12'h008, 32'hF, 0);
        check("reach_busy", 32'(m_busy), 1);
        rstn = 1'b0;
        reg_offset = 12'h004;
        #1;
        check("arst_dp_start", 32'(dp_start), 0);
        check("arst_intr_done", 32'(intr_done), 0);
        check("arst_consumer", 32'(consumer), 0);
        check("arst_producer", 32'(producer), 0);
        check("arst_grp_op_en", 32'(grp_op_en), 0);
        check("arst_pointer", reg_rd_data, 32'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Saturation: preload the count near its ceiling, then complete two operations
        cyc(0, 12'h000, 32'h0, 0);
        force dut.done_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        cyc(0, 12'h000, 32'h0, 0);
        release dut.done_cnt_q;
        cyc(1, 12'h008, 32'h1, 0);
        cyc(0, 12'h000, 32'h0, 0);
        cyc(0, 12'h000, 32'h0, 1);
        rd(12'h00C, 32'hFFFF, "sat_reach");
        cyc(1, 12'h008, 32'h2, 0);
        cyc(0, 12'h000, 32'h0, 0);
        cyc(0, 12'h000, 32'h0, 1);
        rd(12'h00C, 32'hFFFF, "sat_hold");

        repeat (4) cyc(0, 12'h000, 32'h0, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
